sd_read_arbiter: RTL and testbench
==================================

# sd_read_arbiter

Two-requester round-robin arbiter and sequencer for the shared SD word-read engine (CMD17 read path, level start/done handshake). Accepts address requests from two clients (e.g. sprite loader and audio streamer), drives the engine one transaction at a time, returns the 32-bit data word and an error flag to the owning client, and enforces a timeout. Sits between the clients and the single SD read engine that owns CS/D0/D1.

## Interface
- TIMEOUT_CYCLES, 1_000_000: max cycles eng_start stays high waiting for eng_done; ≥ 2.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0_valid  in  1  client 0 requests a read.
- req0_addr  in  32  client 0 SD byte/block address.
- req0_ready  out  1  client 0 request accepted this cycle.
- rsp0_valid  out  1  one-cycle pulse: rsp0_data/rsp0_err valid.
- rsp0_data  out  32  returned word (0 on error).
- rsp0_err  out  1  1 = timeout.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err: same as client 0.
- eng_start  out  1  level start to engine; held until done seen.
- eng_addr  out  32  latched address for engine; stable while eng_start=1.
- eng_data  in  32  engine result word, valid while eng_done=1.
- eng_done  in  1  engine completion level.
- busy  out  1  1 when state ≠ IDLE.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: pick owner by round robin; req*_ready = (state==IDLE) & grant & ~reset, combinational. Accepting cycle latches addr → eng_addr, owner, updates last-granted pointer; next state BUSY.
- Round robin: only one valid → grant it. Both valid → grant the client not last granted. Pointer resets to "last = 1" so client 0 wins first contention.
- BUSY: eng_start=1 (registered). Timeout counter increments each BUSY cycle from 0.
  - eng_done=1 → latch eng_data, err=0, go RELEASE.
  - counter reaches TIMEOUT_CYCLES-1 with eng_done=0 → data=0, err=1, go RELEASE.
  - eng_done and timeout in same cycle → done wins (err=0, real data).
- RELEASE: eng_start=0; owner's rsp*_valid pulses on first RELEASE cycle only with latched data/err. Stay while eng_done=1; go IDLE when eng_done=0 (minimum one RELEASE cycle, guarantees engine sees start low and returns to its halt state).
- Non-owner rsp signals stay 0. req*_valid deasserting after acceptance has no effect on the transaction.
- Counter width: $clog2(TIMEOUT_CYCLES); cleared on entry to BUSY.

## Timing
- Reset values: eng_start=0, eng_addr=0, rsp*_valid=0, rsp*_data=0, rsp*_err=0, busy=0, req*_ready=0, state IDLE, counter 0, pointer=1. Reset mid-transaction drops eng_start immediately (async); no response issued for aborted transaction.
- Accept at cycle T → eng_start=1 from T+1.
- eng_done first seen high at cycle D → rsp_valid=1 at D+1, eng_start=0 at D+1.
- Earliest next accept: D+2 (if eng_done low at D+1 sample). Back-to-back throughput: one transaction per (engine latency + 3) cycles.
- Timeout: eng_start high exactly TIMEOUT_CYCLES cycles, then rsp with err=1.
- rsp*_valid never high two consecutive cycles.

## Structure
- Package sd_pkg: state enum (IDLE, BUSY, RELEASE), owner typedef (1-bit client id), CMD17 code constant 8'h51 shared with the engine.
- One sub-module: sd_rr_pick2 — combinational two-way round-robin grant from (valid0, valid1, last) producing grant id and grant_any; pointer register stays in sd_read_arbiter.

## Test plan
- Single request: req0_valid, addr 0x0000_0200; engine returns 0xDEADBEEF after 10 cycles → req0_ready at T, eng_start T+1..T+10, eng_addr=0x200, rsp0_valid one pulse, rsp0_data=0xDEADBEEF, rsp0_err=0, rsp1_valid never.
- Contention: both valid continuously, addrs 0x100/0x200 → grants alternate 0,1,0,1; eng_addr sequence 0x100,0x200,0x100,0x200.
- Timeout: TIMEOUT_CYCLES=16, engine never asserts done → eng_start high 16 cycles, rsp1_err=1, rsp1_data=0, back to IDLE.
- Done/timeout collision: TIMEOUT_CYCLES=16, eng_done rises on 16th BUSY cycle with 0x12345678 → rsp err=0, data=0x12345678.
- Sticky done: engine holds eng_done 3 cycles after start drops → arbiter stays in RELEASE, no new eng_start until eng_done=0, single rsp pulse.
- Reset mid-BUSY: assert reset 5 cycles into transaction → eng_start=0 asynchronously, no rsp pulse; after release, client 0 wins first contention.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_pkg: shared types and constants for the SD word-read path              |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Client identifier: 0 = client 0, 1 = client 1.
    typedef logic owner_t;

    localparam logic [7:0] CMD17 = 8'h51;

endpackage
`default_nettype wire

// File: rtl/sd_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_rr_pick2: combinational two-way round-robin grant                      |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module sd_rr_pick2
    import sd_pkg::*;
(
    input  logic   valid0,
    input  logic   valid1,
    input  owner_t last,
    output owner_t grant,
    output logic   grant_any
);

    assign grant_any = valid0 | valid1;

    // Under contention the client not granted last time wins.
    assign grant = (valid0 & valid1) ? ~last : valid1;

endmodule
`default_nettype wire

// File: rtl/sd_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_read_arbiter: two-client round-robin sequencer for the SD read engine  |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module sd_read_arbiter
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
)
(
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,

    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,

    output logic        eng_start,
    output logic [31:0] eng_addr,
    input  logic [31:0] eng_data,
    input  logic        eng_done,

    output logic        busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    owner_t           last;
    owner_t           owner;
    owner_t           grant;
    logic             grant_any;
    logic             accept;
    logic             finish;
    logic [CNT_W-1:0] cnt;

    sd_rr_pick2 u_pick (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .last      (last),
        .grant     (grant),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Done and timeout in the same cycle resolve as done.
                if (eng_done || (cnt == CNT_LAST)) begin
                    finish     = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!eng_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = accept & (grant == 1'b0) & ~reset;
    assign req1_ready = accept & (grant == 1'b1) & ~reset;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_start  <= 1'b0;
            eng_addr   <= '0;
            owner      <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            if (accept) begin
                eng_addr <= grant ? req1_addr : req0_addr;
                owner    <= grant;
                last     <= grant;
                cnt      <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end

            eng_start <= accept | ((state == BUSY) & ~finish);

            // Response fields are only non-zero during the owner's single pulse.
            rsp0_valid <= finish & (owner == 1'b0);
            rsp0_err   <= finish & (owner == 1'b0) & ~eng_done;
            rsp0_data  <= (finish & (owner == 1'b0) & eng_done) ? eng_data : '0;
            rsp1_valid <= finish & (owner == 1'b1);
            rsp1_err   <= finish & (owner == 1'b1) & ~eng_done;
            rsp1_data  <= (finish & (owner == 1'b1) & eng_done) ? eng_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sd_read_arbiter: self-checking bench with transaction-level model      |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sd_read_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        eng_start;
    logic [31:0] eng_addr;
    logic [31:0] eng_data;
    logic        eng_done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_last;

    sd_read_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .eng_start  (eng_start),
        .eng_addr   (eng_addr),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One full transaction: request, engine phase of lat BUSY cycles (lat > TO
    // means the engine never answers), then hold extra cycles of sticky done.
    task automatic run_txn(input bit v0, input bit v1, input logic [31:0] a0,
                           input logic [31:0] a1, input int lat, input int hold,
                           input logic [31:0] word, input bit scramble);
        bit          own;
        bit          timed_out;
        logic [31:0] a;
        own       = (v0 && v1) ? ~exp_last : v1;
        a         = own ? a1 : a0;
        timed_out = (lat > TO);
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
        eng_done = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (req0_ready !== !own || req1_ready !== own) begin
            n_bad++; $display("FAIL grant: got ready0=%b ready1=%b want owner %0d", req0_ready, req1_ready, own);
        end
        exp_last = own;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (scramble) begin
                req0_valid = 1'($urandom); req1_valid = 1'($urandom);
                req0_addr = $urandom; req1_addr = $urandom;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            eng_data = $urandom;
            #1;
            n_cmp++;
            if (eng_start !== 1'b1 || eng_addr !== a || busy !== 1'b1) begin
                n_bad++; $display("FAIL busy_cycle%0d: start=%b addr=%h busy=%b want 1/%h/1", k, eng_start, eng_addr, busy, a);
            end
            n_cmp++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                n_bad++; $display("FAIL busy_quiet%0d: rdy=%b%b rsp=%b%b want 0000", k, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
            end
            if (k == lat) begin
                eng_done = 1'b1;
                eng_data = word;
                break;
            end
        end
        for (int j = 1; j <= hold + 1; j++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (eng_start !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL release%0d: start=%b busy=%b want 0/1", j, eng_start, busy);
            end
            n_cmp++;
            if (rsp0_valid !== (j == 1 && !own) || rsp1_valid !== (j == 1 && own)) begin
                n_bad++; $display("FAIL rsp_valid%0d: got %b%b owner %0d", j, rsp1_valid, rsp0_valid, own);
            end
            if (j == 1) begin
                n_cmp++;
                if ((own ? rsp1_data : rsp0_data) !== (timed_out ? 32'h0 : word) ||
                    (own ? rsp1_err : rsp0_err) !== timed_out) begin
                    n_bad++; $display("FAIL rsp_payload: got data=%h err=%b want %h/%b",
                        own ? rsp1_data : rsp0_data, own ? rsp1_err : rsp0_err,
                        timed_out ? 32'h0 : word, timed_out);
                end
                n_cmp++;
                if ((own ? rsp0_data : rsp1_data) !== 32'h0 || (own ? rsp0_err : rsp1_err) !== 1'b0) begin
                    n_bad++; $display("FAIL nonowner_rsp: got data=%h err=%b want 0/0",
                        own ? rsp0_data : rsp1_data, own ? rsp0_err : rsp1_err);
                end
            end
            eng_done = (j <= hold);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 32'h11; req1_addr = 32'h22;
        eng_done = 1'b0; eng_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (eng_start !== 1'b0 || eng_addr !== 32'h0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_eng: start=%b addr=%h busy=%b want 0/0/0", eng_start, eng_addr, busy);
        end
        n_cmp++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
        end
        n_cmp++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_data !== 32'h0 || rsp1_data !== 32'h0 ||
            rsp0_err !== 1'b0 || rsp1_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp: valid=%b%b data=%h/%h err=%b%b want zeros",
                rsp1_valid, rsp0_valid, rsp1_data, rsp0_data, rsp1_err, rsp0_err);
        end
        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_last = 1'b1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 32'h100, 32'h200, $urandom_range(1, 8), 0, $urandom, 1'b0);
        end
    endtask

    task automatic test_single();
        run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 10, 0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0ABC, 1000, 0, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_collision();
        run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, TO, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_sticky();
        run_txn(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0500, 4, 3, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b0; req0_addr = 32'h40; eng_done = 1'b0;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_accept: got %b%b want 01", req1_ready, req0_ready);
        end
        exp_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            req0_valid = 1'b0;
        end
        #1;
        n_cmp++;
        if (eng_start !== 1'b1) begin
            n_bad++; $display("FAIL mid_start: got %b want 1", eng_start);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (eng_start !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: start=%b busy=%b rdy=%b%b want 0/0/00", eng_start, busy, req1_ready, req0_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_rsp: got %b%b want 00", rsp1_valid, rsp0_valid);
        end
        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_last = 1'b1;
        #1;
        n_cmp++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || eng_start !== 1'b0) begin
            n_bad++; $display("FAIL post_reset: rsp=%b%b start=%b want 00/0", rsp1_valid, rsp0_valid, eng_start);
        end
        run_txn(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0700, 3, 0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_random();
        bit v0, v1;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) begin
                @(negedge clk);
                req0_valid = 1'b0; req1_valid = 1'b0; eng_done = 1'b0;
                #1;
                n_cmp++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL idle_norq: rdy=%b%b busy=%b want 00/0", req1_ready, req0_ready, busy);
                end
            end else begin
                run_txn(v0, v1, $urandom, $urandom, $urandom_range(1, TO + 4),
                        $urandom_range(0, 3), $urandom, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_collision();
        test_sticky();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
